// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the two-master memory bus arbiter.
//   arb_state_t : ownership state (IDLE, OWN_M0, OWN_M1)
//   M0 / M1     : master index constants used for 'last', read owner and winner
//   LOCK_CNT_W  : width of the locked-burst grant counter
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN_M0 = 2'd1,
        OWN_M1 = 2'd2
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int LOCK_CNT_W = 8;

endpackage

// File: rtl/mem_arb_pick.sv
// ---------------------------------------------------------------------------
// mem_arb_pick
// Purely combinational winner select for the two-master arbiter.
// Build option: MEM_ARB_ROUND_ROBIN_EN
//   defined   : simultaneous requests alternate (master != last wins)
//   undefined : M0 has fixed priority over M1
// Ports
//   i_req0, i_req1 : master requests
//   i_last         : master granted most recently
//   i_state        : current ownership state
//   i_forced       : lock counter expired; the non-owner gets priority
//   o_valid        : some master wins this cycle (before busy/reset gating)
//   o_winner       : winning master index (M0/M1)
// ---------------------------------------------------------------------------
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic       i_last,
    input  arb_state_t i_state,
    input  logic       i_forced,
    output logic       o_valid,
    output logic       o_winner
);

    logic w_owner;
    logic w_owner_req;
    logic w_both_pick;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        o_valid     = 1'b0;
        o_winner    = M0;
        w_owner     = (i_state == OWN_M1) ? M1 : M0;
        w_owner_req = (w_owner == M1) ? i_req1 : i_req0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        w_both_pick = ~i_last;
`else
        w_both_pick = M0;
`endif
        if ((i_state != IDLE) && !i_forced && w_owner_req) begin
            // Locked burst in progress: the owner alone may be granted.
            o_valid  = 1'b1;
            o_winner = w_owner;
        end else if (i_req0 && i_req1) begin
            // An expired lock hands the contested bus to the other master.
            o_valid  = 1'b1;
            o_winner = i_forced ? ~w_owner : w_both_pick;
        end else if (i_req0) begin
            o_valid  = 1'b1;
            o_winner = M0;
        end else if (i_req1) begin
            o_valid  = 1'b1;
            o_winner = M1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
// Merges CPU (M0) and DMA (M1) accesses onto the single memory_controller
// port. Grants are combinational in the request cycle; read data returns one
// cycle later and is routed to the master that issued the read. A master may
// lock the bus for up to LOCK_MAX consecutive grants.
// Build option: MEM_ARB_ROUND_ROBIN_EN (see mem_arb_pick) selects
// alternating instead of M0-fixed priority for simultaneous requests.
// Ports
//   CLK, RSTb                    : clock, synchronous active-low reset
//   Mx_REQ/WR/LOCK/ADDR/WDATA    : master request side (x = 0, 1)
//   Mx_GNT                       : access accepted this cycle
//   Mx_RVALID/RDATA              : read return, cycle after the read grant
//   ADDRESS/DATA_IN/memWR/memRD  : to memory_controller
//   memBUSY                      : controller busy, blocks all grants
//   DATA_OUT                     : controller read data
// ---------------------------------------------------------------------------
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int BITS         = 16,
    parameter int ADDRESS_BITS = 16,
    parameter int LOCK_MAX     = 8
) (
    input  logic                    CLK,
    input  logic                    RSTb,
    input  logic                    M0_REQ,
    input  logic                    M0_WR,
    input  logic                    M0_LOCK,
    input  logic [ADDRESS_BITS-1:0] M0_ADDR,
    input  logic [BITS-1:0]         M0_WDATA,
    output logic                    M0_GNT,
    output logic                    M0_RVALID,
    output logic [BITS-1:0]         M0_RDATA,
    input  logic                    M1_REQ,
    input  logic                    M1_WR,
    input  logic                    M1_LOCK,
    input  logic [ADDRESS_BITS-1:0] M1_ADDR,
    input  logic [BITS-1:0]         M1_WDATA,
    output logic                    M1_GNT,
    output logic                    M1_RVALID,
    output logic [BITS-1:0]         M1_RDATA,
    output logic [ADDRESS_BITS-1:0] ADDRESS,
    output logic [BITS-1:0]         DATA_IN,
    output logic                    memWR,
    output logic                    memRD,
    input  logic                    memBUSY,
    input  logic [BITS-1:0]         DATA_OUT
);

    localparam logic [LOCK_CNT_W-1:0] LOCK_MAX_C = LOCK_CNT_W'(LOCK_MAX);

    arb_state_t              r_state;
    logic [LOCK_CNT_W-1:0]   r_lock_cnt;
    logic                    r_last;
    logic [ADDRESS_BITS-1:0] r_addr;
    logic [BITS-1:0]         r_wdata;
    logic                    r_rd_pending;
    logic                    r_rd_owner;
    logic [BITS-1:0]         r_rdata0;
    logic [BITS-1:0]         r_rdata1;

    arb_state_t              w_next_state;
    arb_state_t              w_win_own_state;
    logic [LOCK_CNT_W-1:0]   w_next_cnt;
    logic                    w_owner_req;
    logic                    w_forced;
    logic                    w_pick_valid;
    logic                    w_pick_winner;
    logic                    w_gnt;
    logic                    w_win_wr;
    logic                    w_win_lock;
    logic [ADDRESS_BITS-1:0] w_win_addr;
    logic [BITS-1:0]         w_win_wdata;
    logic                    w_rvalid0;
    logic                    w_rvalid1;

    // Owner's request; only meaningful outside IDLE.
    assign w_owner_req = (r_state == OWN_M1) ? M1_REQ : M0_REQ;
    assign w_forced    = (r_state != IDLE) && (r_lock_cnt == LOCK_MAX_C);

    mem_arb_pick u_pick (
        .i_req0   (M0_REQ),
        .i_req1   (M1_REQ),
        .i_last   (r_last),
        .i_state  (r_state),
        .i_forced (w_forced),
        .o_valid  (w_pick_valid),
        .o_winner (w_pick_winner)
    );

    // Reset and busy both suppress the grant so no strobe escapes in those cycles.
    assign w_gnt           = w_pick_valid && !memBUSY && RSTb;
    assign w_win_wr        = (w_pick_winner == M1) ? M1_WR    : M0_WR;
    assign w_win_lock      = (w_pick_winner == M1) ? M1_LOCK  : M0_LOCK;
    assign w_win_addr      = (w_pick_winner == M1) ? M1_ADDR  : M0_ADDR;
    assign w_win_wdata     = (w_pick_winner == M1) ? M1_WDATA : M0_WDATA;
    assign w_win_own_state = (w_pick_winner == M1) ? OWN_M1   : OWN_M0;

    // A pending read is dropped while reset is asserted.
    assign w_rvalid0 = RSTb && r_rd_pending && (r_rd_owner == M0);
    assign w_rvalid1 = RSTb && r_rd_pending && (r_rd_owner == M1);

    // -------- FSM: state register --------
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            r_state    <= IDLE;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_lock_cnt <= w_next_cnt;
        end
    end

    // -------- FSM: next state --------
    // The grant that opens a locked burst counts as its first grant, so the
    // owner gets exactly LOCK_MAX grants before a forced release.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_lock_cnt;
        if (w_gnt) begin
            if (w_win_lock) begin
                if ((r_state == w_win_own_state) && !w_forced) begin
                    w_next_cnt = (r_lock_cnt == LOCK_MAX_C) ? r_lock_cnt
                                                            : r_lock_cnt + LOCK_CNT_W'(1);
                end else begin
                    w_next_state = w_win_own_state;
                    w_next_cnt   = LOCK_CNT_W'(1);
                end
            end else begin
                w_next_state = IDLE;
                w_next_cnt   = '0;
            end
        end else if ((r_state != IDLE) && !w_owner_req) begin
            // Owner went away while nothing could be granted (e.g. busy).
            w_next_state = IDLE;
            w_next_cnt   = '0;
        end
    end

    // -------- FSM: outputs --------
    always_comb begin
        M0_GNT    = w_gnt && (w_pick_winner == M0);
        M1_GNT    = w_gnt && (w_pick_winner == M1);
        memWR     = w_gnt && w_win_wr;
        memRD     = w_gnt && !w_win_wr;
        ADDRESS   = w_gnt ? w_win_addr  : r_addr;
        DATA_IN   = w_gnt ? w_win_wdata : r_wdata;
        M0_RVALID = w_rvalid0;
        M1_RVALID = w_rvalid1;
        M0_RDATA  = w_rvalid0 ? DATA_OUT : r_rdata0;
        M1_RDATA  = w_rvalid1 ? DATA_OUT : r_rdata1;
    end

    // -------- Datapath registers --------
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            r_last       <= M1;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rd_pending <= 1'b0;
            r_rd_owner   <= M0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            if (w_gnt) begin
                r_last  <= w_pick_winner;
                r_addr  <= w_win_addr;
                r_wdata <= w_win_wdata;
            end
            r_rd_pending <= w_gnt && !w_win_wr;
            r_rd_owner   <= w_pick_winner;
            if (w_rvalid0) r_rdata0 <= DATA_OUT;
            if (w_rvalid1) r_rdata1 <= DATA_OUT;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed scenarios followed by randomized traffic, all compared every
// cycle against a behavioural model of the arbitration rules.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int LOCK_MAX = 8;

    logic        CLK = 1'b0;
    logic        RSTb;
    logic        M0_REQ, M0_WR, M0_LOCK;
    logic [15:0] M0_ADDR, M0_WDATA;
    logic        M0_GNT, M0_RVALID;
    logic [15:0] M0_RDATA;
    logic        M1_REQ, M1_WR, M1_LOCK;
    logic [15:0] M1_ADDR, M1_WDATA;
    logic        M1_GNT, M1_RVALID;
    logic [15:0] M1_RDATA;
    logic [15:0] ADDRESS, DATA_IN;
    logic        memWR, memRD, memBUSY;
    logic [15:0] DATA_OUT;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mem_bus_arbiter #(.BITS(16), .ADDRESS_BITS(16), .LOCK_MAX(LOCK_MAX)) dut (
        .CLK(CLK), .RSTb(RSTb),
        .M0_REQ(M0_REQ), .M0_WR(M0_WR), .M0_LOCK(M0_LOCK), .M0_ADDR(M0_ADDR), .M0_WDATA(M0_WDATA),
        .M0_GNT(M0_GNT), .M0_RVALID(M0_RVALID), .M0_RDATA(M0_RDATA),
        .M1_REQ(M1_REQ), .M1_WR(M1_WR), .M1_LOCK(M1_LOCK), .M1_ADDR(M1_ADDR), .M1_WDATA(M1_WDATA),
        .M1_GNT(M1_GNT), .M1_RVALID(M1_RVALID), .M1_RDATA(M1_RDATA),
        .ADDRESS(ADDRESS), .DATA_IN(DATA_IN), .memWR(memWR), .memRD(memRD),
        .memBUSY(memBUSY), .DATA_OUT(DATA_OUT)
    );

    // ---------------- behavioural model ----------------
    int          m_owner;     // -1: nobody holds a lock, else master index
    int          m_cnt;       // grants in the current locked burst
    int          m_last;
    bit          m_rd_pend;
    int          m_rd_own;
    logic [15:0] m_rdata [2];
    logic [15:0] m_addr, m_wdata;
    int          e_gnt;       // expected winner this cycle, -1 for none

    function void model_reset();
        m_owner = -1; m_cnt = 0; m_last = 1;
        m_rd_pend = 0; m_rd_own = 0;
        m_rdata[0] = '0; m_rdata[1] = '0;
        m_addr = '0; m_wdata = '0;
    endfunction

    function bit req_of(int m);   return (m == 0) ? M0_REQ : M1_REQ;     endfunction
    function bit wr_of(int m);    return (m == 0) ? M0_WR : M1_WR;       endfunction
    function bit lock_of(int m);  return (m == 0) ? M0_LOCK : M1_LOCK;   endfunction
    function logic [15:0] addr_of(int m);  return (m == 0) ? M0_ADDR : M1_ADDR;   endfunction
    function logic [15:0] wdata_of(int m); return (m == 0) ? M0_WDATA : M1_WDATA; endfunction

    function int model_grant();
        if (!RSTb || memBUSY) return -1;
        if (m_owner >= 0 && req_of(m_owner) && m_cnt < LOCK_MAX) return m_owner;
        if (M0_REQ && M1_REQ) begin
            if (m_owner >= 0 && m_cnt >= LOCK_MAX) return 1 - m_owner;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            return 1 - m_last;
`else
            return 0;
`endif
        end
        if (M0_REQ) return 0;
        if (M1_REQ) return 1;
        return -1;
    endfunction

    function bit exp_rvalid(int m);
        return RSTb && m_rd_pend && (m_rd_own == m);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called 1 time unit before the rising edge; compares every output.
    task automatic sample();
        #4;
        e_gnt = model_grant();
        chk("gnt0",    M0_GNT,    32'(e_gnt == 0));
        chk("gnt1",    M1_GNT,    32'(e_gnt == 1));
        chk("memWR",   memWR,     32'(e_gnt >= 0 && wr_of(e_gnt)));
        chk("memRD",   memRD,     32'(e_gnt >= 0 && !wr_of(e_gnt)));
        chk("ADDRESS", ADDRESS,   32'((e_gnt >= 0) ? addr_of(e_gnt) : m_addr));
        chk("DATA_IN", DATA_IN,   32'((e_gnt >= 0) ? wdata_of(e_gnt) : m_wdata));
        chk("rvalid0", M0_RVALID, 32'(exp_rvalid(0)));
        chk("rvalid1", M1_RVALID, 32'(exp_rvalid(1)));
        chk("rdata0",  M0_RDATA,  32'(exp_rvalid(0) ? DATA_OUT : m_rdata[0]));
        chk("rdata1",  M1_RDATA,  32'(exp_rvalid(1) ? DATA_OUT : m_rdata[1]));
    endtask

    // Crosses the rising edge and advances the model with the same inputs.
    task automatic adv();
        @(negedge CLK);
        if (!RSTb) begin
            model_reset();
        end else begin
            for (int m = 0; m < 2; m++)
                if (exp_rvalid(m)) m_rdata[m] = DATA_OUT;
            if (e_gnt >= 0) begin
                m_last    = e_gnt;
                m_addr    = addr_of(e_gnt);
                m_wdata   = wdata_of(e_gnt);
                m_rd_pend = !wr_of(e_gnt);
                m_rd_own  = e_gnt;
                if (lock_of(e_gnt)) begin
                    if (m_owner == e_gnt && m_cnt < LOCK_MAX) m_cnt++;
                    else begin m_owner = e_gnt; m_cnt = 1; end
                end else begin
                    m_owner = -1; m_cnt = 0;
                end
            end else begin
                m_rd_pend = 0;
                if (m_owner >= 0 && !req_of(m_owner)) begin m_owner = -1; m_cnt = 0; end
            end
        end
    endtask

    task automatic set_m0(input bit req, input bit wr, input bit lock, input logic [15:0] a, input logic [15:0] d);
        M0_REQ = req; M0_WR = wr; M0_LOCK = lock; M0_ADDR = a; M0_WDATA = d;
    endtask

    task automatic set_m1(input bit req, input bit wr, input bit lock, input logic [15:0] a, input logic [15:0] d);
        M1_REQ = req; M1_WR = wr; M1_LOCK = lock; M1_ADDR = a; M1_WDATA = d;
    endtask

    initial begin
        int n1;
        int first_m0;
        bit exp_g0;

        model_reset();
        e_gnt = -1;
        RSTb = 1'b0; memBUSY = 1'b0; DATA_OUT = 16'h0;
        set_m0(1, 0, 0, 16'h0010, 16'h1111);
        set_m1(1, 0, 0, 16'h0020, 16'h2222);
        @(negedge CLK);
        model_reset();

        // 1. reset held with both masters requesting
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("rst_gnt0", M0_GNT, 0);
            chk("rst_gnt1", M1_GNT, 0);
            chk("rst_strobes", {memRD, memWR}, 0);
            adv();
        end

        // 2. lone M0 read, data returned next cycle
        RSTb = 1'b1;
        set_m1(0, 0, 0, 16'h0020, 16'h2222);
        set_m0(1, 0, 0, 16'h1004, 16'h0);
        sample();
        chk("t2_gnt", M0_GNT, 1);
        chk("t2_memRD", memRD, 1);
        chk("t2_addr", ADDRESS, 16'h1004);
        adv();
        M0_REQ = 1'b0; DATA_OUT = 16'hA5C3;
        sample();
        chk("t2_rvalid", M0_RVALID, 1);
        chk("t2_rdata", M0_RDATA, 16'hA5C3);
        adv();

        // 3. one M1 write so that M0 is "not last", then both request 4 cycles
        set_m1(1, 1, 0, 16'h0200, 16'h0B0B);
        sample(); adv();
        set_m0(1, 1, 0, 16'h0300, 16'h0C0C);
        for (int i = 0; i < 4; i++) begin
            sample();
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_g0 = (i % 2 == 0);
`else
            exp_g0 = 1'b1;
`endif
            chk("t3_gnt0", M0_GNT, 32'(exp_g0));
            chk("t3_gnt1", M1_GNT, 32'(!exp_g0));
            adv();
        end

        // 4. M1 locked burst, M0 joins after the first grant
        set_m0(0, 1, 0, 16'h0400, 16'h0D0D);
        set_m1(1, 0, 1, 16'h0500, 16'h0);
        n1 = 0; first_m0 = -1;
        sample();
        if (M1_GNT) n1++;
        adv();
        M0_REQ = 1'b1;
        for (int i = 1; i < 13; i++) begin
            DATA_OUT = 16'($urandom);
            M1_ADDR = 16'h0500 + 16'(i);
            sample();
            if (first_m0 < 0) begin
                if (M0_GNT) first_m0 = i;
                else if (M1_GNT) n1++;
            end
            adv();
        end
        chk("t4_m1_grants", n1, LOCK_MAX);
        chk("t4_m0_cycle", first_m0, LOCK_MAX);

        // 5. busy blocks grants and strobes
        set_m1(0, 0, 0, 16'h0, 16'h0);
        set_m0(1, 1, 0, 16'h0600, 16'h6666);
        memBUSY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("t5_busy_gnt", M0_GNT, 0);
            chk("t5_busy_strobes", {memRD, memWR}, 0);
            adv();
        end
        memBUSY = 1'b0;
        sample();
        chk("t5_gnt", M0_GNT, 1);
        adv();

        // 6. read then reset: return dropped; then a write
        set_m0(1, 0, 0, 16'h0700, 16'h0);
        sample(); adv();
        M0_REQ = 1'b0; RSTb = 1'b0; DATA_OUT = 16'h7777;
        sample();
        chk("t6_rst_rvalid", M0_RVALID, 0);
        adv();
        RSTb = 1'b1;
        sample();
        chk("t6_post_rvalid", M0_RVALID, 0);
        adv();
        set_m0(1, 1, 0, 16'h4000, 16'hBEEF);
        sample();
        chk("t6_memWR", memWR, 1);
        chk("t6_data_in", DATA_IN, 16'hBEEF);
        chk("t6_addr", ADDRESS, 16'h4000);
        adv();
        M0_REQ = 1'b0;
        sample();
        chk("t6_wr_rvalid", M0_RVALID, 0);
        adv();

        // 7. randomized traffic; requests are held until granted
        for (int n = 0; n < 600; n++) begin
            RSTb     = ($urandom_range(0, 59) != 0);
            memBUSY  = ($urandom_range(0, 3) == 0);
            DATA_OUT = 16'($urandom);
            if (!M0_REQ || e_gnt == 0)
                set_m0($urandom_range(0, 2) != 0, 1'($urandom), $urandom_range(0, 2) == 0,
                       16'($urandom), 16'($urandom));
            if (!M1_REQ || e_gnt == 1)
                set_m1($urandom_range(0, 2) != 0, 1'($urandom), $urandom_range(0, 1) == 0,
                       16'($urandom), 16'($urandom));
            sample();
            adv();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
